// File: rtl/truss_watchdog_pkg.sv
// Shared types and helpers for the truss watchdog array.
//   wd_state_t     : per-channel watchdog state
//   first_set_idx  : LSB-first priority encoder over a 32-bit vector
package truss_watchdog_pkg;

    typedef enum logic [1:0] {
        WD_IDLE    = 2'd0,
        WD_RUNNING = 2'd1,
        WD_EXPIRED = 2'd2
    } wd_state_t;

    // Returns the index of the lowest set bit; 0 when the vector is empty.
    // Scanning from the top down lets the lowest index overwrite the result last.
    function automatic logic [4:0] first_set_idx(input logic [31:0] i_vec);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (i_vec[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/truss_watchdog_chan.sv
// One watchdog channel: state, counter, limit, rearm mode and timeout pulse.
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_cfg_we                 load i_cfg_limit / i_cfg_rearm at this edge
//   i_cfg_limit, i_cfg_rearm new limit (0 = never expires) and auto-rearm mode
//   i_arm, i_kick, i_disarm  start / heartbeat / stop controls
//   o_expire                 expiry happens at the coming edge (combinational)
//   o_pulse                  registered one-cycle pulse after each expiry edge
//   o_state                  current state, exposed for debug
// Control priority: reset > disarm > arm > kick > count.
module truss_watchdog_chan
    import truss_watchdog_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cfg_we,
    input  logic [CNT_W-1:0] i_cfg_limit,
    input  logic             i_cfg_rearm,
    input  logic             i_arm,
    input  logic             i_kick,
    input  logic             i_disarm,
    output logic             o_expire,
    output logic             o_pulse,
    output wd_state_t        o_state
);

    wd_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_limit;
    logic             r_rearm;
    logic             r_pulse;
    logic             w_expire;

    // Expiry uses the limit in force before any cfg write at this edge.
    // A limit already at or below cnt never matches once cnt saturates; that is
    // a programming error and the channel simply never expires.
    always_comb begin
        w_expire = (r_state == WD_RUNNING) && !i_disarm && !i_arm && !i_kick &&
                   (r_limit != '0) && (r_cnt == r_limit - CNT_W'(1));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= WD_IDLE;
            r_cnt   <= '0;
            r_limit <= '0;
            r_rearm <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_expire;
            // Configuration never touches the running count.
            if (i_cfg_we) begin
                r_limit <= i_cfg_limit;
                r_rearm <= i_cfg_rearm;
            end
            if (i_disarm) begin
                r_state <= WD_IDLE;
                r_cnt   <= '0;
            end else if (i_arm) begin
                r_state <= WD_RUNNING;
                r_cnt   <= '0;
            end else if (r_state == WD_RUNNING) begin
                if (i_kick) begin
                    r_cnt <= '0;
                end else if (w_expire) begin
                    if (r_rearm) begin
                        r_cnt <= '0;
                    end else begin
                        r_state <= WD_EXPIRED;
                    end
                end else if (r_cnt != '1) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_expire = w_expire;
    assign o_pulse  = r_pulse;
    assign o_state  = r_state;

endmodule

// File: rtl/truss_watchdog_array.sv
// N-channel hardware watchdog with sticky status and first-expiry capture.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cfg_we/cfg_chan     write cfg_limit/cfg_rearm into channel cfg_chan
//   cfg_limit/cfg_rearm limit in cycles (0 = never expires), auto-rearm mode
//   arm/kick/disarm     per-channel start, heartbeat, stop
//   clr_status          per-channel clear of sticky timed_out; any bit clears first_valid
//   timeout_pulse       one-cycle pulse per expiry
//   timed_out           sticky expiry flags (set wins over clear)
//   any_timeout         registered OR of timed_out
//   first_valid/first_chan  lowest-index channel of the first expiry since clear
//   dbg_state           per-channel state, 2 bits per channel, channel 0 in [1:0]
module truss_watchdog_array
    import truss_watchdog_pkg::*;
#(
    parameter int N_CHAN     = 4,
    parameter int CNT_W      = 32,
    parameter int CHAN_IDX_W = ($clog2(N_CHAN) > 0) ? $clog2(N_CHAN) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [CHAN_IDX_W-1:0] cfg_chan,
    input  logic [CNT_W-1:0]      cfg_limit,
    input  logic                  cfg_rearm,
    input  logic [N_CHAN-1:0]     arm,
    input  logic [N_CHAN-1:0]     kick,
    input  logic [N_CHAN-1:0]     disarm,
    input  logic [N_CHAN-1:0]     clr_status,
    output logic [N_CHAN-1:0]     timeout_pulse,
    output logic [N_CHAN-1:0]     timed_out,
    output logic                  any_timeout,
    output logic                  first_valid,
    output logic [CHAN_IDX_W-1:0] first_chan,
    output logic [2*N_CHAN-1:0]   dbg_state
);

    logic [N_CHAN-1:0]     w_expire;
    logic [N_CHAN-1:0]     w_pulse;
    logic [N_CHAN-1:0]     w_cfg_sel;
    logic [N_CHAN-1:0]     w_timed_next;
    logic                  w_capture;
    logic [CHAN_IDX_W-1:0] w_first_idx;
    wd_state_t             w_state [N_CHAN];

    logic [N_CHAN-1:0]     r_timed_out;
    logic                  r_any_timeout;
    logic                  r_first_valid;
    logic [CHAN_IDX_W-1:0] r_first_chan;

    for (genvar g = 0; g < N_CHAN; g++) begin : g_chan
        // An out-of-range cfg_chan matches no channel, so the write is dropped.
        assign w_cfg_sel[g] = cfg_we && (cfg_chan == CHAN_IDX_W'(g));

        truss_watchdog_chan #(.CNT_W(CNT_W)) u_chan (
            .i_clk       (clk),
            .i_reset     (reset),
            .i_cfg_we    (w_cfg_sel[g]),
            .i_cfg_limit (cfg_limit),
            .i_cfg_rearm (cfg_rearm),
            .i_arm       (arm[g]),
            .i_kick      (kick[g]),
            .i_disarm    (disarm[g]),
            .o_expire    (w_expire[g]),
            .o_pulse     (w_pulse[g]),
            .o_state     (w_state[g])
        );

        assign dbg_state[2*g +: 2] = w_state[g];
    end

    always_comb begin
        w_timed_next = (r_timed_out & ~clr_status) | w_expire;
        w_first_idx  = CHAN_IDX_W'(first_set_idx(32'(w_expire)));
        // A clear and a new expiry in the same cycle recaptures immediately.
        w_capture    = (|w_expire) && (!r_first_valid || (|clr_status));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timed_out   <= '0;
            r_any_timeout <= 1'b0;
            r_first_valid <= 1'b0;
            r_first_chan  <= '0;
        end else begin
            r_timed_out   <= w_timed_next;
            r_any_timeout <= |w_timed_next;
            if (w_capture) begin
                r_first_valid <= 1'b1;
                r_first_chan  <= w_first_idx;
            end else if (|clr_status) begin
                r_first_valid <= 1'b0;
            end
        end
    end

    assign timeout_pulse = w_pulse;
    assign timed_out     = r_timed_out;
    assign any_timeout   = r_any_timeout;
    assign first_valid   = r_first_valid;
    assign first_chan    = r_first_chan;

endmodule

// File: tb/tb_truss_watchdog_array.sv
// Self-checking bench for truss_watchdog_array: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a behavioural model.
module tb_truss_watchdog_array;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;
    localparam int CNT_MAX = (1 << W) - 1;
    localparam int S_IDLE = 0, S_RUN = 1, S_EXP = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_we;
    logic [IW-1:0] cfg_chan;
    logic [W-1:0]  cfg_limit;
    logic          cfg_rearm;
    logic [N-1:0]  arm, kick, disarm, clr_status;
    logic [N-1:0]  timeout_pulse, timed_out;
    logic          any_timeout, first_valid;
    logic [IW-1:0] first_chan;
    logic [2*N-1:0] dbg_state;

    truss_watchdog_array #(.N_CHAN(N), .CNT_W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_we        (cfg_we),
        .cfg_chan      (cfg_chan),
        .cfg_limit     (cfg_limit),
        .cfg_rearm     (cfg_rearm),
        .arm           (arm),
        .kick          (kick),
        .disarm        (disarm),
        .clr_status    (clr_status),
        .timeout_pulse (timeout_pulse),
        .timed_out     (timed_out),
        .any_timeout   (any_timeout),
        .first_valid   (first_valid),
        .first_chan    (first_chan),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: each channel tracks cycles elapsed since its last
    // arm/kick/rearm; it expires on the cycle that elapsed count reaches limit.
    int           m_state [N];
    int           m_cnt   [N];
    int           m_limit [N];
    bit           m_rearm [N];
    logic [N-1:0] m_pulse, m_timed;
    bit           m_any, m_fv;
    int           m_fc;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_state[i] = S_IDLE; m_cnt[i] = 0; m_limit[i] = 0; m_rearm[i] = 0;
        end
        m_pulse = '0; m_timed = '0; m_any = 0; m_fv = 0; m_fc = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] ev;
        if (reset) begin
            model_reset();
            return;
        end
        ev = '0;
        for (int i = 0; i < N; i++) begin
            if (m_state[i] == S_RUN && !disarm[i] && !arm[i] && !kick[i] &&
                m_limit[i] != 0 && m_cnt[i] + 1 == m_limit[i])
                ev[i] = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (disarm[i]) begin
                m_state[i] = S_IDLE; m_cnt[i] = 0;
            end else if (arm[i]) begin
                m_state[i] = S_RUN; m_cnt[i] = 0;
            end else if (m_state[i] == S_RUN) begin
                if (kick[i]) m_cnt[i] = 0;
                else if (ev[i]) begin
                    if (m_rearm[i]) m_cnt[i] = 0;
                    else m_state[i] = S_EXP;
                end else if (m_cnt[i] < CNT_MAX) m_cnt[i] = m_cnt[i] + 1;
            end
        end
        if (cfg_we && int'(cfg_chan) < N) begin
            m_limit[cfg_chan] = int'(cfg_limit);
            m_rearm[cfg_chan] = cfg_rearm;
        end
        m_pulse = ev;
        m_timed = (m_timed & ~clr_status) | ev;
        m_any   = (m_timed != '0);
        if (clr_status != '0) m_fv = 0;
        if (!m_fv && ev != '0) begin
            m_fv = 1;
            for (int i = N - 1; i >= 0; i--) if (ev[i]) m_fc = i;
        end
    endtask

    task automatic clear_inputs();
        cfg_we = 0; cfg_chan = '0; cfg_limit = '0; cfg_rearm = 0;
        arm = '0; kick = '0; disarm = '0; clr_status = '0;
    endtask

    // One clock: model advances with the inputs now applied, then outputs are
    // sampled 1 ns after the edge and one-shot controls are dropped.
    task automatic step();
        logic [2*N-1:0] st;
        model_step();
        @(posedge clk);
        #1;
        st = '0;
        for (int i = 0; i < N; i++) st[2*i +: 2] = 2'(m_state[i]);
        check("pulse", timeout_pulse, m_pulse);
        check("timed_out", timed_out, m_timed);
        check("any_timeout", any_timeout, m_any);
        check("first_valid", first_valid, m_fv);
        if (m_fv) check("first_chan", first_chan, m_fc);
        check("state", dbg_state, st);
        clear_inputs();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic cfg(input int ch, input int lim, input bit rr);
        cfg_we = 1; cfg_chan = IW'(ch); cfg_limit = W'(lim); cfg_rearm = rr;
        step();
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        model_reset();
        steps(2);
        reset = 0;
        check("rst_pulse", timeout_pulse, 0);
        check("rst_timed", timed_out, 0);
        check("rst_first", {first_valid, first_chan}, 0);

        // 1: limit 5, arm at E0, pulse after E5
        cfg(0, 5, 0);
        arm = 4'b0001; step();
        steps(4);
        check("s1_early", timeout_pulse, 4'b0000);
        step();
        check("s1_pulse", timeout_pulse, 4'b0001);
        check("s1_timed", timed_out, 4'b0001);
        check("s1_first", {first_valid, first_chan}, {1'b1, 2'd0});

        // 2: kicked every 3 cycles never expires, then pulse 4 after last kick
        cfg(1, 4, 0);
        arm = 4'b0010; step();
        for (int k = 0; k < 7; k++) begin
            steps(2);
            kick = 4'b0010; step();
        end
        check("s2_nopulse", timed_out[1], 1'b0);
        steps(3);
        check("s2_early", timeout_pulse[1], 1'b0);
        step();
        check("s2_pulse", timeout_pulse[1], 1'b1);

        // 3: auto-rearm pulses every 3 cycles, stays RUNNING
        cfg(2, 3, 1);
        arm = 4'b0100; step();
        steps(10);
        check("s3_state", dbg_state[5:4], 2'(S_RUN));
        disarm = 4'b0100; step();

        // 4: simultaneous expiry, lowest index captured, then clear
        clr_status = 4'b1111; step();
        cfg(0, 6, 0);
        cfg(3, 6, 0);
        arm = 4'b1001; step();
        steps(6);
        check("s4_pulse", timeout_pulse, 4'b1001);
        check("s4_first", {first_valid, first_chan}, {1'b1, 2'd0});
        clr_status = 4'b1001; step();
        check("s4_clr", {timed_out, any_timeout, first_valid}, 0);

        // 5: reset mid-count, channel forgets its limit
        cfg(1, 8, 0);
        arm = 4'b0010; step();
        steps(5);
        reset = 1; step();
        reset = 0;
        check("s5_rst", {timeout_pulse, timed_out, any_timeout, first_valid}, 0);
        arm = 4'b0010; step();
        steps(20);
        check("s5_never", timed_out, 0);

        // 6: disarm beats arm; expiry beats clear and is recaptured
        cfg(0, 3, 0);
        disarm = 4'b0001; arm = 4'b0001; step();
        check("s6_idle", dbg_state[1:0], 2'(S_IDLE));
        arm = 4'b0001; step();
        steps(2);
        clr_status = 4'b0001; step();
        check("s6_timed", timed_out[0], 1'b1);
        check("s6_first", {first_valid, first_chan}, {1'b1, 2'd0});

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 5) == 0) begin
                cfg_we = 1; cfg_chan = IW'($urandom_range(0, N - 1));
                cfg_limit = W'($urandom_range(0, 12)); cfg_rearm = 1'($urandom_range(0, 1));
            end
            for (int i = 0; i < N; i++) begin
                arm[i]        = ($urandom_range(0, 15) == 0);
                kick[i]       = ($urandom_range(0, 5) == 0);
                disarm[i]     = ($urandom_range(0, 49) == 0);
                clr_status[i] = ($urandom_range(0, 19) == 0);
            end
            step();
            reset = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
